// File: rtl/event_arbiter_if.sv
// rtl/event_arbiter_if.sv - handshake bundle between frontend module fifos, arbiter and ethernet fifo
//
// Signals:
//   in_valid  [NMODULES]         per-module event available (fifo not empty)
//   in_ready  [NMODULES]         per-module pop strobe, at most one high
//   in_data   [NMODULES*LENGTH]  module i at [i*LENGTH +: LENGTH]
//   out_valid                    event presented to the ethernet fifo
//   out_ready                    ethernet fifo not full
//   out_data  [LENGTH]           event word
//   out_src   [2]                index of the producing module
// Modports:
//   master  the arbiter side
//   slave   the environment side (module fifos + ethernet fifo)

interface event_arbiter_if #(
  parameter int NMODULES = 4,
  parameter int LENGTH   = 128
);
  logic [NMODULES-1:0]        in_valid;
  logic [NMODULES-1:0]        in_ready;
  logic [NMODULES*LENGTH-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [LENGTH-1:0]          out_data;
  logic [1:0]                 out_src;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/event_arbiter.sv
// rtl/event_arbiter.sv - burst-limited round-robin arbiter merging module event fifos into one stream
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active low
//   bus       event_arbiter_if.master (per-module inputs, merged output)
//   wait_clr  (EVENT_ARBITER_WAIT_MON_EN only) clears wait_max
//   wait_max  (EVENT_ARBITER_WAIT_MON_EN only) longest starvation run seen, in cycles
// Optional feature macro: EVENT_ARBITER_WAIT_MON_EN

module event_arbiter #(
  parameter int NMODULES = 4,
  parameter int LENGTH   = 128,
  parameter int BURST    = 4
) (
  input  logic               clk,
  input  logic               rst,
  event_arbiter_if.master    bus
`ifdef EVENT_ARBITER_WAIT_MON_EN
  ,
  input  logic               wait_clr,
  output logic [15:0]        wait_max
`endif
);

  localparam int          IW      = (NMODULES > 1) ? $clog2(NMODULES) : 1;
  localparam logic [3:0]  BURST_L = 4'(BURST);

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state_q;
  logic [IW-1:0]       owner_q;
  logic [3:0]          burst_cnt_q;

  // Two-entry buffer: head drives the outputs directly, skid holds the
  // word accepted while the head is stalled.
  logic                out_valid_q;
  logic [LENGTH-1:0]   out_data_q;
  logic [1:0]          out_src_q;
  logic                skid_valid_q;
  logic [LENGTH-1:0]   skid_data_q;
  logic [1:0]          skid_src_q;

  logic [1:0]          entries;
  logic                accept;
  logic                keep;
  logic                grant_any;
  logic [IW-1:0]       grant_idx;
  logic [IW-1:0]       cand;
  logic                fire;
  logic                pop;
  logic [NMODULES-1:0] in_ready_c;
  logic [LENGTH-1:0]   grant_data;

  always_comb begin
    entries    = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    accept     = (entries == 2'd0) | (entries == 2'd1);
    keep       = (state_q == OWN) && bus.in_valid[owner_q] && (burst_cnt_q < BURST_L);
    grant_any  = 1'b0;
    grant_idx  = owner_q;
    cand       = '0;
    if (keep) begin
      grant_any = 1'b1;
    end else begin
      // Walk from the farthest candidate back to owner+1 so the nearest
      // valid source after the owner is the one left standing.
      for (int k = NMODULES; k >= 1; k--) begin
        cand = IW'((int'(owner_q) + k) % NMODULES);
        if (bus.in_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    // rst gating keeps in_ready silent in the cycle a reset is applied.
    fire = grant_any & accept & rst;
    for (int i = 0; i < NMODULES; i++) begin
      in_ready_c[i] = fire && (grant_idx == IW'(i));
    end
    grant_data = bus.in_data[grant_idx*LENGTH +: LENGTH];
    pop        = out_valid_q & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= IW'(NMODULES - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_src_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (fire) state_q <= OWN;
        OWN:  if (bus.in_valid == '0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (fire) begin
        if (keep) begin
          burst_cnt_q <= burst_cnt_q + 4'd1;
        end else begin
          owner_q     <= grant_idx;
          burst_cnt_q <= 4'd1;
        end
      end

      if (!out_valid_q) begin
        if (fire) begin
          out_valid_q <= 1'b1;
          out_data_q  <= grant_data;
          out_src_q   <= 2'(grant_idx);
        end
      end else if (!skid_valid_q) begin
        if (fire && pop) begin
          out_data_q <= grant_data;
          out_src_q  <= 2'(grant_idx);
        end else if (fire) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= grant_data;
          skid_src_q   <= 2'(grant_idx);
        end else if (pop) begin
          out_valid_q <= 1'b0;
        end
      end else if (pop) begin
        // Full: accept is low, so only the skid-to-head move can happen.
        out_data_q   <= skid_data_q;
        out_src_q    <= skid_src_q;
        skid_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef EVENT_ARBITER_WAIT_MON_EN
  logic [15:0] wcnt_q [NMODULES];
  logic [15:0] wcnt_d [NMODULES];
  logic [15:0] wait_max_q;
  logic [15:0] wait_max_d;
  logic        waiting;

  // A run is folded into the maximum on the edge that ends it, so the
  // new value is visible the cycle after the wait ends.
  always_comb begin
    wait_max_d = wait_max_q;
    waiting    = 1'b0;
    for (int i = 0; i < NMODULES; i++) begin
      waiting = bus.in_valid[i] & ~in_ready_c[i];
      if (waiting) begin
        wcnt_d[i] = (wcnt_q[i] == 16'hFFFF) ? wcnt_q[i] : wcnt_q[i] + 16'd1;
      end else begin
        wcnt_d[i] = '0;
        if (wcnt_q[i] > wait_max_d) wait_max_d = wcnt_q[i];
      end
    end
    if (wait_clr) wait_max_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_max_q <= '0;
      for (int i = 0; i < NMODULES; i++) wcnt_q[i] <= '0;
    end else begin
      wait_max_q <= wait_max_d;
      for (int i = 0; i < NMODULES; i++) wcnt_q[i] <= wcnt_d[i];
    end
  end

  assign wait_max = wait_max_q;
`endif

endmodule
